// File: rtl/m3ramp_pkg.sv
// Shared types and defaults for the m3freq_ramp soft-start/soft-stop slew limiter.
package m3ramp_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        STOPPING  = 2'd2,
        REVERSING = 2'd3
    } m3ramp_state_t;

    localparam int M3_FREQ_W      = 10;
    localparam int M3_STEP_CYCLES = 100000;
    localparam int M3_DEB_CYCLES  = 50000;

endpackage

// File: rtl/m3ramp_tick.sv
// Step prescaler: one-cycle tick every STEP_CYCLES clocks, held at zero while hold is high.
module m3ramp_tick
    import m3ramp_pkg::*;
#(
    parameter int STEP_CYCLES = M3_STEP_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic hold,
    output logic tick
);

    localparam int CNT_W = $clog2(STEP_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);

    logic [CNT_W-1:0] countReg;

    always_ff @(posedge clk) begin
        if (rst || hold) begin
            countReg <= '0;
        end else if (countReg == CNT_LAST) begin
            countReg <= '0;
        end else begin
            countReg <= countReg + 1'b1;
        end
    end

    assign tick = !hold && (countReg == CNT_LAST);

endmodule

// File: rtl/m3freq_ramp.sv
// Frequency slew limiter and reversal sequencer in front of the motor drive core.
// Optional control-input debounce filter enabled by defining M3RAMP_DEBOUNCE_EN.
module m3freq_ramp
    import m3ramp_pkg::*;
#(
    parameter int FREQ_W      = M3_FREQ_W,
    parameter int STEP_CYCLES = M3_STEP_CYCLES,
    parameter int DEB_CYCLES  = M3_DEB_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m3start,
    input  logic              m3invOrStop,
    input  logic [FREQ_W-1:0] m3freq,
    output logic [FREQ_W-1:0] rampFreq,
    output logic              rampDir,
    output logic              rampRun,
    output logic              rampBusy,
    output logic              atSpeed
);

    localparam logic [1:0] ST_IDLE      = IDLE;
    localparam logic [1:0] ST_RUN       = RUN;
    localparam logic [1:0] ST_STOPPING  = STOPPING;
    localparam logic [1:0] ST_REVERSING = REVERSING;

    // Bit 0 carries start, bit 1 carries the reverse request.
    logic [1:0] ctrlMetaReg;
    logic [1:0] ctrlSyncReg;
    logic [1:0] ctrlFilt;

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrlMetaReg <= '0;
            ctrlSyncReg <= '0;
        end else begin
            ctrlMetaReg <= {m3invOrStop, m3start};
            ctrlSyncReg <= ctrlMetaReg;
        end
    end

`ifdef M3RAMP_DEBOUNCE_EN
    localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_deb
            logic [DEB_W-1:0] debCntReg;
            logic             debOutReg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    debCntReg <= '0;
                    debOutReg <= 1'b0;
                end else if (ctrlSyncReg[gi] == debOutReg) begin
                    debCntReg <= '0;
                end else if (debCntReg == DEB_LAST) begin
                    debCntReg <= '0;
                    debOutReg <= ctrlSyncReg[gi];
                end else begin
                    debCntReg <= debCntReg + 1'b1;
                end
            end

            assign ctrlFilt[gi] = debOutReg;
        end
    endgenerate
`else
    assign ctrlFilt = ctrlSyncReg;
`endif

    logic invPrevReg;
    logic startLvl;
    logic revEdge;

    always_ff @(posedge clk) begin
        if (rst) begin
            invPrevReg <= 1'b0;
        end else begin
            invPrevReg <= ctrlFilt[1];
        end
    end

    assign startLvl = ctrlFilt[0];
    assign revEdge  = ctrlFilt[1] && !invPrevReg;

    logic [1:0]        stateReg, stateNext;
    logic [FREQ_W-1:0] freqReg, freqNext;
    logic              dirReg, dirNext;
    logic              runReg, runNext;
    logic              busyReg, busyNext;
    logic              atReg, atNext;
    logic [FREQ_W-1:0] targetNext;
    logic              tick;

    m3ramp_tick #(
        .STEP_CYCLES(STEP_CYCLES)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .hold(stateReg == ST_IDLE),
        .tick(tick)
    );

    // Stop wins over reverse, reverse wins over slew; a transition cycle takes no step.
    always_comb begin
        stateNext = stateReg;
        freqNext  = freqReg;
        dirNext   = dirReg;
        case (stateReg)
            ST_IDLE: begin
                freqNext = '0;
                if (startLvl) begin
                    stateNext = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!startLvl) begin
                    stateNext = ST_STOPPING;
                end else if (revEdge) begin
                    stateNext = ST_REVERSING;
                end else if (tick) begin
                    if (freqReg < m3freq) begin
                        freqNext = freqReg + 1'b1;
                    end else if (freqReg > m3freq) begin
                        freqNext = freqReg - 1'b1;
                    end
                end
            end
            ST_STOPPING: begin
                if (freqReg == '0) begin
                    stateNext = ST_IDLE;
                end else if (tick) begin
                    freqNext = freqReg - 1'b1;
                    if (freqReg == FREQ_W'(1)) begin
                        stateNext = ST_IDLE;
                    end
                end
            end
            default: begin
                if (!startLvl) begin
                    stateNext = ST_STOPPING;
                end else if (freqReg == '0) begin
                    dirNext   = !dirReg;
                    stateNext = ST_RUN;
                end else if (tick) begin
                    freqNext = freqReg - 1'b1;
                    // Direction flips on the same edge that lands on zero.
                    if (freqReg == FREQ_W'(1)) begin
                        dirNext   = !dirReg;
                        stateNext = ST_RUN;
                    end
                end
            end
        endcase
    end

    always_comb begin
        targetNext = (stateNext == ST_RUN) ? m3freq : '0;
        runNext    = (stateNext != ST_IDLE);
        busyNext   = (freqNext != targetNext) || (stateNext == ST_STOPPING) ||
                     (stateNext == ST_REVERSING);
        atNext     = (stateNext == ST_RUN) && (freqNext == m3freq);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg <= ST_IDLE;
            freqReg  <= '0;
            dirReg   <= 1'b0;
            runReg   <= 1'b0;
            busyReg  <= 1'b0;
            atReg    <= 1'b0;
        end else begin
            stateReg <= stateNext;
            freqReg  <= freqNext;
            dirReg   <= dirNext;
            runReg   <= runNext;
            busyReg  <= busyNext;
            atReg    <= atNext;
        end
    end

    assign rampFreq = freqReg;
    assign rampDir  = dirReg;
    assign rampRun  = runReg;
    assign rampBusy = busyReg;
    assign atSpeed  = atReg;

endmodule
